tt_fpga_io_bridge: RTL and testbench
====================================

# tt_fpga_io_bridge

Parametrised FPGA-side pad bridge between board pins and a Tiny Tapeout-style user core (ui/uo/uio/ena/rst_n). It is the next generation of the plain tristate wrapper and adds the following:
- configurable bus widths;
- N-stage input synchronisers;
- registered outputs;
- a per-bit bidirectional turnaround state machine that guarantees dead cycles on every direction change;
- a core reset stretcher;
- an internal loopback mode for board bring-up.

It sits at the top of each FPGA build, directly under the board pin constraints.

## Interface
Parameters:
- UI_W, 8: dedicated input width.
- UO_W, 8: dedicated output width.
- UIO_W, 8: bidirectional width.
- SYNC_STAGES, 2: input synchroniser depth. Legal values are 0–3; 0 means combinational bypass.
- TURN_CYCLES, 1: high-Z dead cycles inserted on each uio direction change. Legal values are 0–7.
- RST_HOLD, 16: cycles that core_rst_n stays low after rst deasserts. Minimum is 1.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: reset. One clock; reset is asynchronous and active-high.
- loopback, in, 1: loopback mode select. It is static and is sampled synchronously.
- ui_pad, in, UI_W: board input pins.
- uo_pad, out, UO_W: board output pins.
- uio_pad, inout, UIO_W: board bidirectional pins.
- core_ui_in, out, UI_W: synchronised inputs to the core.
- core_uo_out, in, UO_W: core dedicated outputs.
- core_uio_in, out, UIO_W: synchronised uio readback to the core.
- core_uio_out, in, UIO_W: core uio drive data.
- core_uio_oe, in, UIO_W: core per-bit output-enable request.
- core_rst_n, out, 1: stretched active-low core reset.
- core_ena, out, 1: core enable.

## Operation
- Reset values while rst is high (all asynchronous):
  - core_rst_n=0 and core_ena=0.
  - uo_pad=0.
  - Every synchroniser flop is 0, so core_ui_in=0 and core_uio_in=0.
  - All uio FSMs are in IN, so uio_pad is all high-Z.
  - The hold counter is 0.
- Reset stretcher:
  - The counter increments each clk while rst=0 and saturates at RST_HOLD.
  - core_rst_n is 1 exactly when the counter equals RST_HOLD.
  - core_ena is core_rst_n delayed by one register.
  - Reasserting rst mid-count clears the counter immediately.
- Input path:
  - ui_pad passes through SYNC_STAGES flops to core_ui_in.
  - uio_pad passes through the same chain to core_uio_in.
  - The uio sample is taken from the pad in every state, so the core reads back its own driven value.
- Output path: uo_pad is core_uo_out registered once.
- uio data path: the drive value is core_uio_out registered once. It reaches the pad only when that bit's FSM is in OUT.
- Per-bit FSM (state plus a 3-bit turn counter):
  - IN: pad high-Z. If the effective request is 1, go to TURN_OUT with cnt=TURN_CYCLES; when TURN_CYCLES=0, go directly to OUT.
  - TURN_OUT: pad high-Z. If the request drops, return to IN. Else if cnt==1, go to OUT. Else decrement cnt.
  - OUT: pad driven. If the request is 0, go to TURN_IN with cnt=TURN_CYCLES; when TURN_CYCLES=0, go directly to IN.
  - TURN_IN: pad high-Z. If the request rises, return to OUT. Else if cnt==1, go to IN. Else decrement cnt.
- Effective request is core_uio_oe[i] & ~loopback & core_rst_n. While the core is held in reset, every pin drifts to high-Z.
- Loopback=1:
  - core_ui_in[i] is core_uo_out[i mod UO_W] registered once, bypassing the synchroniser.
  - core_uio_in[i] is core_uio_out[i] registered once.
  - uo_pad keeps operating normally.
  - All uio pins turn around to IN through the normal dead cycles.
- Simultaneous events in the same cycle resolve per the FSM table above; rst overrides everything.

## Timing
- ui_pad to core_ui_in latency is SYNC_STAGES cycles. With SYNC_STAGES=0 the path is combinational.
- core_uo_out to uo_pad latency is 1 cycle.
- Drive start: with core_uio_oe[i] rising, sampled at edge k, the pad is driven from edge k+1+TURN_CYCLES, showing the core_uio_out value sampled at the preceding edge.
- Release: with oe falling, sampled at edge k, the pad is high-Z from edge k+1 and the FSM is in IN at edge k+1+TURN_CYCLES.
- A pin is never driven in the same cycle that it leaves IN or TURN_OUT, except when TURN_CYCLES=0.
- core_rst_n rises at the RST_HOLD-th rising edge after rst falls; core_ena rises one edge later.

## Test plan
- Reset release, RST_HOLD=16: rst low at edge 0 -> core_rst_n=1 at edge 16, core_ena=1 at edge 17. Pulsing rst at edge 10 restarts the count.
- Synchroniser latency, SYNC_STAGES=2: step ui_pad 0x00->0xA5 -> core_ui_in=0xA5 exactly 2 edges later. Repeat with SYNC_STAGES=0 -> combinational.
- Turnaround, TURN_CYCLES=2, core_uio_out=0x3C:
  - raise oe=0xFF at edge k -> uio_pad high-Z at edges k+1 and k+2, driven 0x3C from edge k+3;
  - drop oe -> high-Z from the next edge, FSM in IN 2 edges later.
- Abort: raise oe for 1 cycle during TURN_OUT (TURN_CYCLES=3) -> pin never driven, FSM returns to IN.
- Loopback: loopback=1, core_uo_out=0x5A, core_uio_out=0xC3 -> core_ui_in=0x5A and core_uio_in=0xC3 one cycle later, uio_pad fully high-Z after TURN_CYCLES+1 cycles, uo_pad=0x5A.
- Reset mid-drive: assert rst while a pin is in OUT -> pin high-Z asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/tt_fpga_io_bridge.sv
// -----------------------------------------------------------------------------
// tt_fpga_io_bridge
//
// FPGA pad bridge between board pins and a Tiny Tapeout-style user core.
// It provides input synchronisers, registered outputs, per-bit bidirectional
// turnaround state machines with guaranteed high-Z dead cycles, a core reset
// stretcher and an internal loopback mode for board bring-up.
//
// Ports:
//   clk          - sole clock
//   rst          - asynchronous active-high reset
//   loopback     - static loopback select, sampled on clk
//   ui_pad       - board dedicated input pins            [UI_W]
//   uo_pad       - board dedicated output pins           [UO_W]
//   uio_pad      - board bidirectional pins              [UIO_W]
//   core_ui_in   - synchronised (or looped-back) inputs  [UI_W]
//   core_uo_out  - core dedicated outputs                [UO_W]
//   core_uio_in  - synchronised (or looped-back) uio     [UIO_W]
//   core_uio_out - core uio drive data                   [UIO_W]
//   core_uio_oe  - core per-bit output-enable request    [UIO_W]
//   core_rst_n   - stretched active-low core reset
//   core_ena     - core enable, core_rst_n delayed one cycle
// -----------------------------------------------------------------------------
module tt_fpga_io_bridge #(
    parameter int UI_W        = 8,
    parameter int UO_W        = 8,
    parameter int UIO_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYCLES = 1,
    parameter int RST_HOLD    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loopback,
    input  logic [UI_W-1:0]  ui_pad,
    output logic [UO_W-1:0]  uo_pad,
    inout  wire  [UIO_W-1:0] uio_pad,
    output logic [UI_W-1:0]  core_ui_in,
    input  logic [UO_W-1:0]  core_uo_out,
    output logic [UIO_W-1:0] core_uio_in,
    input  logic [UIO_W-1:0] core_uio_out,
    input  logic [UIO_W-1:0] core_uio_oe,
    output logic             core_rst_n,
    output logic             core_ena
);

    localparam int           HOLD_W    = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);
    localparam logic [2:0]   TURN_INIT = 3'(TURN_CYCLES);
    localparam logic         TURN_ZERO = (TURN_CYCLES == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IN       = 2'd0,
        ST_TURN_OUT = 2'd1,
        ST_OUT      = 2'd2,
        ST_TURN_IN  = 2'd3
    } uio_state_e;

    // ------------------------------------------------------------------
    // Reset stretcher
    // ------------------------------------------------------------------
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              core_ena_q, core_ena_d;

    // Saturating hold counter; core_rst_n tracks "counter at RST_HOLD".
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
        core_rst_n_d = (hold_cnt_d == HOLD_MAX);
        core_ena_d   = core_rst_n_q;
    end

    // Reset stretcher registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
            core_ena_q   <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            core_ena_q   <= core_ena_d;
        end
    end

    // ------------------------------------------------------------------
    // Input synchronisers (ui and uio share the same depth)
    // ------------------------------------------------------------------
    logic [UI_W-1:0]  ui_sync;
    logic [UIO_W-1:0] uio_sync;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign ui_sync  = ui_pad;
            assign uio_sync = uio_pad;
        end else begin : g_sync
            logic [UI_W-1:0]  ui_q  [SYNC_STAGES];
            logic [UI_W-1:0]  ui_d  [SYNC_STAGES];
            logic [UIO_W-1:0] uio_q [SYNC_STAGES];
            logic [UIO_W-1:0] uio_d [SYNC_STAGES];

            // Shift chain: stage 0 samples the pads, later stages follow.
            always_comb begin
                ui_d[0]  = ui_pad;
                uio_d[0] = uio_pad;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    ui_d[s]  = ui_q[s-1];
                    uio_d[s] = uio_q[s-1];
                end
            end

            // Synchroniser flops.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        ui_q[s]  <= '0;
                        uio_q[s] <= '0;
                    end
                end else begin
                    ui_q  <= ui_d;
                    uio_q <= uio_d;
                end
            end

            assign ui_sync  = ui_q[SYNC_STAGES-1];
            assign uio_sync = uio_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output, drive data, request and loopback registers
    // ------------------------------------------------------------------
    logic [UO_W-1:0]  uo_q, uo_d;
    logic [UIO_W-1:0] drv_q, drv_d;
    logic [UIO_W-1:0] req_q, req_d;
    logic             loopback_q, loopback_d;
    logic [UI_W-1:0]  lb_ui_q, lb_ui_d;
    logic [UIO_W-1:0] lb_uio_q, lb_uio_d;

    // Next values for the single-stage data registers. The effective
    // request is masked by loopback and by the core still being in reset,
    // so every pin drifts back to IN whenever either holds.
    always_comb begin
        uo_d       = core_uo_out;
        drv_d      = core_uio_out;
        req_d      = core_uio_oe & {UIO_W{~loopback & core_rst_n_q}};
        loopback_d = loopback;
        lb_uio_d   = core_uio_out;
        for (int i = 0; i < UI_W; i++) begin
            lb_ui_d[i] = core_uo_out[i % UO_W];
        end
    end

    // Data path registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uo_q       <= '0;
            drv_q      <= '0;
            req_q      <= '0;
            loopback_q <= 1'b0;
            lb_ui_q    <= '0;
            lb_uio_q   <= '0;
        end else begin
            uo_q       <= uo_d;
            drv_q      <= drv_d;
            req_q      <= req_d;
            loopback_q <= loopback_d;
            lb_ui_q    <= lb_ui_d;
            lb_uio_q   <= lb_uio_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit turnaround FSMs
    // ------------------------------------------------------------------
    uio_state_e       state_q [UIO_W];
    uio_state_e       state_d [UIO_W];
    logic [2:0]       cnt_q   [UIO_W];
    logic [2:0]       cnt_d   [UIO_W];
    logic [UIO_W-1:0] pad_oe_q, pad_oe_d;

    // Turnaround next-state logic. The pad enable is registered from the
    // next state so the pin is driven exactly while the FSM sits in OUT.
    always_comb begin
        for (int i = 0; i < UIO_W; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IN: begin
                    if (req_q[i]) begin
                        if (TURN_ZERO) begin
                            state_d[i] = ST_OUT;
                        end else begin
                            state_d[i] = ST_TURN_OUT;
                            cnt_d[i]   = TURN_INIT;
                        end
                    end else begin
                        state_d[i] = ST_IN;
                    end
                end
                ST_TURN_OUT: begin
                    if (!req_q[i]) begin
                        state_d[i] = ST_IN;
                    end else if (cnt_q[i] == 3'd1) begin
                        state_d[i] = ST_OUT;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 3'd1;
                    end
                end
                ST_OUT: begin
                    if (!req_q[i]) begin
                        if (TURN_ZERO) begin
                            state_d[i] = ST_IN;
                        end else begin
                            state_d[i] = ST_TURN_IN;
                            cnt_d[i]   = TURN_INIT;
                        end
                    end else begin
                        state_d[i] = ST_OUT;
                    end
                end
                ST_TURN_IN: begin
                    if (req_q[i]) begin
                        state_d[i] = ST_OUT;
                    end else if (cnt_q[i] == 3'd1) begin
                        state_d[i] = ST_IN;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 3'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_IN;
                    cnt_d[i]   = 3'd0;
                end
            endcase
            pad_oe_d[i] = (state_d[i] == ST_OUT);
        end
    end

    // Turnaround FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < UIO_W; i++) begin
                state_q[i] <= ST_IN;
                cnt_q[i]   <= 3'd0;
            end
            pad_oe_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pad_oe_q <= pad_oe_d;
        end
    end

    // ------------------------------------------------------------------
    // Pad drivers and core-facing outputs
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < UIO_W; g++) begin : g_pad
            assign uio_pad[g] = pad_oe_q[g] ? drv_q[g] : 1'bz;
        end
    endgenerate

    assign uo_pad      = uo_q;
    assign core_ui_in  = loopback_q ? lb_ui_q : ui_sync;
    assign core_uio_in = loopback_q ? lb_uio_q : uio_sync;
    assign core_rst_n  = core_rst_n_q;
    assign core_ena    = core_ena_q;

endmodule

// File: tb/tb_tt_fpga_io_bridge.sv
// -----------------------------------------------------------------------------
// Directed bench for tt_fpga_io_bridge. Two instances share stimulus:
//   dut_a: SYNC_STAGES=2, TURN_CYCLES=2, RST_HOLD=16
//   dut_b: SYNC_STAGES=0, TURN_CYCLES=3, RST_HOLD=4
// Each uio bus has pull-ups, so a released pad reads back as all ones.
// -----------------------------------------------------------------------------
module tb_tt_fpga_io_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       loopback;
    logic [7:0] ui_pad;
    logic [7:0] core_uo_out;
    logic [7:0] core_uio_out;
    logic [7:0] core_uio_oe;

    logic [7:0] uo_pad_a, core_ui_in_a, core_uio_in_a;
    logic [7:0] uo_pad_b, core_ui_in_b, core_uio_in_b;
    logic       core_rst_n_a, core_ena_a, core_rst_n_b, core_ena_b;
    wire  [7:0] uio_pad_a;
    wire  [7:0] uio_pad_b;

    int tests;
    int fails;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (uio_pad_a[g]);
        pullup (uio_pad_b[g]);
    end

    tt_fpga_io_bridge #(
        .UI_W(8), .UO_W(8), .UIO_W(8),
        .SYNC_STAGES(2), .TURN_CYCLES(2), .RST_HOLD(16)
    ) dut_a (
        .clk(clk), .rst(rst), .loopback(loopback),
        .ui_pad(ui_pad), .uo_pad(uo_pad_a), .uio_pad(uio_pad_a),
        .core_ui_in(core_ui_in_a), .core_uo_out(core_uo_out),
        .core_uio_in(core_uio_in_a), .core_uio_out(core_uio_out),
        .core_uio_oe(core_uio_oe), .core_rst_n(core_rst_n_a),
        .core_ena(core_ena_a)
    );

    tt_fpga_io_bridge #(
        .UI_W(8), .UO_W(8), .UIO_W(8),
        .SYNC_STAGES(0), .TURN_CYCLES(3), .RST_HOLD(4)
    ) dut_b (
        .clk(clk), .rst(rst), .loopback(loopback),
        .ui_pad(ui_pad), .uo_pad(uo_pad_b), .uio_pad(uio_pad_b),
        .core_ui_in(core_ui_in_b), .core_uo_out(core_uo_out),
        .core_uio_in(core_uio_in_b), .core_uio_out(core_uio_out),
        .core_uio_oe(core_uio_oe), .core_rst_n(core_rst_n_b),
        .core_ena(core_ena_b)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        loopback     = 1'b0;
        ui_pad       = 8'h00;
        core_uo_out  = 8'h00;
        core_uio_out = 8'h00;
        core_uio_oe  = 8'h00;

        // Reset state
        tick(2);
        check("rst_core_rst_n_a", 32'(core_rst_n_a), 32'h0);
        check("rst_core_ena_a",   32'(core_ena_a),   32'h0);
        check("rst_uo_pad_a",     32'(uo_pad_a),     32'h00);
        check("rst_ui_in_a",      32'(core_ui_in_a), 32'h00);
        check("rst_uio_in_a",     32'(core_uio_in_a), 32'h00);
        check("rst_uio_pad_a",    32'(uio_pad_a),    32'hFF);
        check("rst_state_a",      32'(dut_a.state_q[0]), 32'h0);
        check("rst_core_rst_n_b", 32'(core_rst_n_b), 32'h0);

        // Reset stretcher with a restart pulse at edge 10
        rst = 1'b0;
        tick(10);
        check("hold_a_edge10", 32'(core_rst_n_a), 32'h0);
        check("hold_b_edge10", 32'(core_rst_n_b), 32'h1);
        check("ena_b_edge10",  32'(core_ena_b),   32'h1);
        rst = 1'b1;
        #2;
        check("pulse_rst_n_b_async", 32'(core_rst_n_b), 32'h0);
        check("pulse_ena_b_async",   32'(core_ena_b),   32'h0);
        rst = 1'b0;
        tick(15);
        check("hold_a_edge15", 32'(core_rst_n_a), 32'h0);
        tick(1);
        check("hold_a_edge16", 32'(core_rst_n_a), 32'h1);
        check("ena_a_edge16",  32'(core_ena_a),   32'h0);
        tick(1);
        check("ena_a_edge17",  32'(core_ena_a),   32'h1);

        // Synchroniser latency
        ui_pad = 8'hA5;
        #1;
        check("sync0_comb_b",  32'(core_ui_in_b), 32'hA5);
        check("sync2_pre_a",   32'(core_ui_in_a), 32'h00);
        tick(1);
        check("sync2_edge1_a", 32'(core_ui_in_a), 32'h00);
        tick(1);
        check("sync2_edge2_a", 32'(core_ui_in_a), 32'hA5);

        // Turnaround: oe rises, sampled at edge k
        core_uio_out = 8'h3C;
        core_uio_oe  = 8'hFF;
        tick(1);
        check("turn_k_a",   32'(uio_pad_a), 32'hFF);
        tick(1);
        check("turn_k1_a",  32'(uio_pad_a), 32'hFF);
        tick(1);
        check("turn_k2_a",  32'(uio_pad_a), 32'hFF);
        tick(1);
        check("turn_k3_a",  32'(uio_pad_a), 32'h3C);
        check("turn_k3_b",  32'(uio_pad_b), 32'hFF);
        tick(1);
        check("turn_k4_b",  32'(uio_pad_b), 32'h3C);
        check("readback_b", 32'(core_uio_in_b), 32'h3C);
        tick(1);
        check("readback_a", 32'(core_uio_in_a), 32'h3C);

        // Release: oe falls, sampled at edge m
        core_uio_oe = 8'h00;
        tick(1);
        check("rel_m_a",        32'(uio_pad_a), 32'h3C);
        tick(1);
        check("rel_m1_a",       32'(uio_pad_a), 32'hFF);
        tick(1);
        check("rel_m2_state_a", 32'(dut_a.state_q[0]), 32'h3);
        tick(1);
        check("rel_m3_state_a", 32'(dut_a.state_q[0]), 32'h0);
        tick(1);
        check("rel_m4_state_b", 32'(dut_b.state_q[0]), 32'h0);

        // Abort: one-cycle oe pulse during TURN_OUT
        core_uio_oe = 8'hFF;
        tick(1);
        core_uio_oe = 8'h00;
        tick(1);
        check("abort_k1_state_b", 32'(dut_b.state_q[0]), 32'h1);
        check("abort_k1_pad_b",   32'(uio_pad_b), 32'hFF);
        tick(1);
        check("abort_k2_state_b", 32'(dut_b.state_q[0]), 32'h0);
        tick(3);
        check("abort_pad_b", 32'(uio_pad_b), 32'hFF);
        check("abort_pad_a", 32'(uio_pad_a), 32'hFF);

        // Loopback from a driving state
        core_uio_oe = 8'hFF;
        tick(6);
        check("lb_pre_pad_a", 32'(uio_pad_a), 32'h3C);
        loopback     = 1'b1;
        core_uo_out  = 8'h5A;
        core_uio_out = 8'hC3;
        tick(1);
        check("lb_ui_in_a",  32'(core_ui_in_a),  32'h5A);
        check("lb_uio_in_a", 32'(core_uio_in_a), 32'hC3);
        check("lb_uo_pad_a", 32'(uo_pad_a),      32'h5A);
        check("lb_ui_in_b",  32'(core_ui_in_b),  32'h5A);
        check("lb_uio_in_b", 32'(core_uio_in_b), 32'hC3);
        tick(3);
        check("lb_pad_a",    32'(uio_pad_a), 32'hFF);
        check("lb_state_a",  32'(dut_a.state_q[7]), 32'h0);
        tick(1);
        check("lb_pad_b",    32'(uio_pad_b), 32'hFF);
        check("lb_state_b",  32'(dut_b.state_q[7]), 32'h0);

        // Reset while driving
        loopback = 1'b0;
        tick(6);
        check("mid_pre_pad_a", 32'(uio_pad_a), 32'hC3);
        rst = 1'b1;
        #1;
        check("mid_pad_a",       32'(uio_pad_a),     32'hFF);
        check("mid_pad_b",       32'(uio_pad_b),     32'hFF);
        check("mid_uo_pad_a",    32'(uo_pad_a),      32'h00);
        check("mid_ui_in_a",     32'(core_ui_in_a),  32'h00);
        check("mid_uio_in_a",    32'(core_uio_in_a), 32'h00);
        check("mid_core_rst_n_a", 32'(core_rst_n_a), 32'h0);
        check("mid_core_ena_a",  32'(core_ena_a),    32'h0);
        rst = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
